// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EX-stage divide issue controller and the multi-cycle divider.
interface div_issue_ctrl_if;
    logic [7:0]  div_alucontrol;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_start;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    modport master (
        output div_alucontrol, div_opa, div_opb, div_start, div_annul,
        input  div_result, div_ready
    );

    modport slave (
        input  div_alucontrol, div_opa, div_opb, div_start, div_annul,
        output div_result, div_ready
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage divide issue controller: launches DIV/DIVU on the divider, stalls the pipe
// while it runs, and owns the HI/LO registers (divide results and MTHI/MTLO).
module div_issue_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              alucontrol,
    input  logic [31:0]             srca,
    input  logic [31:0]             srcb,
    input  logic                    flush_i,
    div_issue_ctrl_if.master        dv,
    output logic                    stall_o,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o
);
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] drain_cnt, drain_nxt;
    logic          start_nxt, annul_nxt;
    logic          issue, commit;
    logic          is_div;

    assign is_div = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        start_nxt = dv.div_start;
        annul_nxt = dv.div_annul;
        stall_o   = 1'b0;
        issue     = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                stall_o = is_div && !flush_i;
                if (is_div && !flush_i) begin
                    issue     = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall_o = !dv.div_ready;
                // A result arriving alongside a flush is still committed.
                if (dv.div_ready) begin
                    commit    = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (flush_i) begin
                    start_nxt = 1'b0;
                    annul_nxt = 1'b1;
                    drain_nxt = CW'(DRAIN_CYCLES - 1);
                    state_nxt = ABORT;
                end
            end
            DONE: begin
                stall_o   = is_div;
                state_nxt = IDLE;
            end
            ABORT: begin
                stall_o   = is_div;
                start_nxt = 1'b0;
                annul_nxt = 1'b1;
                if (drain_cnt == '0) begin
                    annul_nxt = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    drain_nxt = drain_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            drain_cnt         <= '0;
            dv.div_start      <= 1'b0;
            dv.div_annul      <= 1'b0;
            dv.div_opa        <= '0;
            dv.div_opb        <= '0;
            dv.div_alucontrol <= '0;
            hi_o              <= '0;
            lo_o              <= '0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_nxt;
            dv.div_start <= start_nxt;
            dv.div_annul <= annul_nxt;
            if (issue) begin
                dv.div_opa        <= srca;
                dv.div_opb        <= srcb;
                dv.div_alucontrol <= alucontrol;
            end
            // Divide completion outranks a same-cycle MTHI/MTLO.
            if (commit) begin
                hi_o <= dv.div_result[63:32];
                lo_o <= dv.div_result[31:0];
            end else if (!flush_i && !stall_o) begin
                if (alucontrol == EXE_MTHI_OP) hi_o <= srca;
                if (alucontrol == EXE_MTLO_OP) lo_o <= srca;
            end
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized scoreboard bench for div_issue_ctrl with a behavioural divider and HI/LO model.
module tb_div_issue_ctrl;
    localparam logic [7:0] DIV  = 8'b0001_1010;
    localparam logic [7:0] DIVU = 8'b0001_1011;
    localparam logic [7:0] MTHI = 8'b0001_0001;
    localparam logic [7:0] MTLO = 8'b0001_0011;
    localparam logic [7:0] NOP  = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alucontrol;
    logic [31:0] srca, srcb;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] hi_o, lo_o;

    div_issue_ctrl_if dif();

    div_issue_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .alucontrol(alucontrol), .srca(srca), .srcb(srcb),
        .flush_i(flush_i), .dv(dif.master), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    bit          div_out = 1'b0;
    int          lat_cfg = 6;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Architectural divide: HI = remainder, LO = quotient; zero divisor yields zeros.
    function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (op == DIV) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: result after lat_cfg cycles (1 for a zero divisor), held while start is high.
    int cnt;
    bit running;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dif.div_ready  <= 1'b0;
            dif.div_result <= '0;
            cnt            <= 0;
            running        <= 1'b0;
        end else if (!dif.div_start || dif.div_annul) begin
            dif.div_ready <= 1'b0;
            running       <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
            cnt     <= (dif.div_opb == 32'd0) ? 1 : lat_cfg;
        end else if (cnt > 1) begin
            cnt <= cnt - 1;
        end else if (!dif.div_ready) begin
            dif.div_ready  <= 1'b1;
            dif.div_result <= ref_div(dif.div_alucontrol, dif.div_opa, dif.div_opb);
        end
    end

    // Monitor: HI/LO are compared after every edge that should write them.
    always @(posedge clk) begin
        bit ev;
        logic [63:0] e;
        ev = 1'b0;
        if (!rst) begin
            if (div_out && dif.div_ready === 1'b1) begin
                ev = 1'b1;
                div_out = 1'b0;
            end else if (!stall_o && !flush_i && (alucontrol == MTHI || alucontrol == MTLO)) begin
                ev = 1'b1;
            end
        end
        if (ev) begin
            #1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_write: hi/lo %h%h with no expected entry", hi_o, lo_o);
            end else begin
                e = exp_q.pop_front();
                check("hilo", {hi_o, lo_o}, e);
            end
        end
    end

    task automatic nop();
        @(negedge clk);
        alucontrol = NOP; srca = $urandom; srcb = $urandom; flush_i = 1'b0;
    endtask

    task automatic mt(input logic [7:0] op, input logic [31:0] v);
        @(negedge clk);
        alucontrol = op; srca = v; srcb = $urandom; flush_i = 1'b0;
        if (op == MTHI) m_hi = v; else m_lo = v;
        exp_q.push_back({m_hi, m_lo});
        #1 check("mt_stall", stall_o, 0);
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag, output int n);
        logic [63:0] e;
        int exp_n;
        exp_n = ((b == 32'd0) ? 1 : lat_cfg) + 1;
        @(negedge clk);
        alucontrol = op; srca = a; srcb = b; flush_i = 1'b0;
        e = ref_div(op, a, b);
        m_hi = e[63:32]; m_lo = e[31:0];
        exp_q.push_back(e);
        div_out = 1'b1;
        #1 check({tag, "_stall_issue"}, stall_o, 1);
        @(negedge clk);
        check({tag, "_start"}, dif.div_start, 1);
        n = 0;
        while (dif.div_ready !== 1'b1 && n < 200) begin
            check({tag, "_stall_busy"}, stall_o, 1);
            check({tag, "_held"}, {dif.div_alucontrol, dif.div_opa, dif.div_opb}, {op, a, b});
            srca = $urandom; srcb = $urandom;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, exp_n);
        check({tag, "_stall_ready"}, stall_o, 0);
        @(negedge clk);
        alucontrol = NOP;
        check({tag, "_start_fall"}, dif.div_start, 0);
    endtask

    initial begin
        int n;
        logic [31:0] hp, lp, a, b;
        int sel;
        rst = 1'b1; alucontrol = NOP; srca = '0; srcb = '0; flush_i = 1'b0;
        #1;
        check("reset_div_regs", {dif.div_start, dif.div_annul, dif.div_alucontrol, dif.div_opa, dif.div_opb}, 0);
        check("reset_hilo", {hi_o, lo_o}, 0);
        check("reset_stall", stall_o, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_div(DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", n);
        run_div(DIVU, 32'd100, 32'd7, "divu", n);
        run_div(DIV, 32'd1234, 32'd0, "dbz", n);
        check("dbz_early", n, 2);

        // Flush 10 cycles into a long divide.
        lat_cfg = 34;
        hp = m_hi; lp = m_lo;
        @(negedge clk);
        alucontrol = DIV; srca = $urandom; srcb = 32'd5; div_out = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1 check("flush_stall", stall_o, 1);
        @(negedge clk);
        flush_i = 1'b0; alucontrol = NOP;
        for (int i = 0; i < 3; i++) begin
            check("abort_annul", dif.div_annul, 1);
            check("abort_start", dif.div_start, 0);
            check("abort_hilo", {hi_o, lo_o}, {hp, lp});
            @(negedge clk);
        end
        check("abort_annul_clear", dif.div_annul, 0);
        lat_cfg = 6;
        run_div(DIVU, 32'd9, 32'd2, "post_abort", n);

        mt(MTHI, 32'hDEAD_BEEF);
        mt(MTLO, 32'h1234_5678);
        nop();

        // MTHI waiting behind a running divide.
        hp = m_hi; lp = m_lo;
        @(negedge clk);
        alucontrol = DIV; srca = 32'd50; srcb = 32'hFFFF_FFFA; flush_i = 1'b0;
        exp_q.push_back(ref_div(DIV, 32'd50, 32'hFFFF_FFFA));
        {m_hi, m_lo} = ref_div(DIV, 32'd50, 32'hFFFF_FFFA);
        div_out = 1'b1;
        @(negedge clk);
        alucontrol = MTHI; srca = 32'hCAFE_F00D;
        n = 0;
        while (dif.div_ready !== 1'b1 && n < 200) begin
            check("busy_mthi_blocked", {hi_o, lo_o}, {hp, lp});
            @(negedge clk);
            n++;
        end
        check("busy_mthi_timeout", n < 200, 1);
        @(negedge clk);
        m_hi = 32'hCAFE_F00D;
        exp_q.push_back({m_hi, m_lo});
        #1 check("done_mthi_stall", stall_o, 0);
        nop();

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 4);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(1, 50);
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            lat_cfg = $urandom_range(1, 10);
            case (sel)
                0: run_div(DIV, a, b, "rnd_div", n);
                1: run_div(DIVU, a, b, "rnd_divu", n);
                2: mt(MTHI, a);
                3: mt(MTLO, a);
                default: nop();
            endcase
        end
        nop();
        if (hi_o == 32'd0) mt(MTHI, 32'h0BAD_F00D);
        nop();

        // Asynchronous reset in the middle of a divide.
        lat_cfg = 20;
        @(negedge clk);
        alucontrol = DIV; srca = $urandom; srcb = 32'd3; div_out = 1'b0;
        repeat (4) @(negedge clk);
        alucontrol = NOP;
        #2 rst = 1'b1;
        #1;
        check("async_rst_div_regs", {dif.div_start, dif.div_annul, dif.div_alucontrol, dif.div_opa, dif.div_opb}, 0);
        check("async_rst_hilo", {hi_o, lo_o}, 0);
        check("async_rst_stall", stall_o, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        lat_cfg = 6;
        run_div(DIV, 32'd77, 32'hFFFF_FFF6, "post_rst", n);
        nop(); nop();
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end
endmodule
